// File: rtl/hog_bus_drain.sv
// Drains HOG result words from a bus slave into a first-word-fall-through FIFO.
// Optional ack timeout is enabled by defining HOG_DRAIN_TIMEOUT_EN.
module hog_bus_drain #(
  parameter int ADDR_WIDTH = 5,
  parameter int BUS_WIDTH  = 128,
  parameter int READ_ADDR  = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   irq,
  input  logic                   ack,
  input  logic [BUS_WIDTH-1:0]   read_data,
  output logic                   bus_enable,
  output logic                   r_wbar,
  output logic [ADDR_WIDTH-1:0]  addr,
  output logic [BUS_WIDTH/8-1:0] byte_enable,
  output logic [BUS_WIDTH-4:0]   m_data,
  output logic [2:0]             m_meta,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   timeout_err,
  output logic [15:0]            word_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_READ    = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [ADDR_WIDTH-1:0] RD_ADDR = ADDR_WIDTH'(READ_ADDR);

  logic [1:0]           state_q, state_d;
  logic [BUS_WIDTH-1:0] cap_q, cap_d;
  logic [BUS_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [BUS_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0]          word_count_q, word_count_d;
  logic [BUS_WIDTH-1:0] head;
  logic                 fifo_empty, fifo_full, push, pop, tmo_hit;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign push = (state_q == S_CAPTURE) && (cap_q[BUS_WIDTH-1 -: 3] != 3'b000);
  assign pop  = !fifo_empty && m_ready;

`ifdef HOG_DRAIN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          timeout_err_q, timeout_err_d;

  assign tmo_hit = (state_q == S_READ) && !ack && (tmo_cnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    tmo_cnt_d     = (state_q == S_READ) ? tmo_cnt_q + TW'(1) : '0;
    timeout_err_d = timeout_err_q | tmo_hit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Room is checked only at issue; with one read outstanding a push never overflows.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (irq && !fifo_full) state_d = S_READ;
      S_READ:    if (ack) state_d = S_CAPTURE;
                 else if (tmo_hit) state_d = S_IDLE;
      S_CAPTURE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cap_d = ((state_q == S_READ) && ack) ? read_data : cap_q;
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q[PTR_W-1:0]] = cap_q;
    wr_ptr_d     = wr_ptr_q + (PTR_W + 1)'(push);
    rd_ptr_d     = rd_ptr_q + (PTR_W + 1)'(pop);
    word_count_d = word_count_q + 16'(push);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      word_count_q <= word_count_d;
    end
  end

  // Data storage is not reset; outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    cap_q <= cap_d;
    mem_q <= mem_d;
  end

  assign head        = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign m_valid     = !fifo_empty;
  assign m_data      = m_valid ? head[BUS_WIDTH-4:0] : '0;
  assign m_meta      = m_valid ? head[BUS_WIDTH-1 -: 3] : 3'b000;
  assign bus_enable  = (state_q == S_READ);
  assign r_wbar      = bus_enable;
  assign addr        = bus_enable ? RD_ADDR : '0;
  assign byte_enable = {(BUS_WIDTH/8){bus_enable}};
  assign word_count  = word_count_q;

endmodule

// File: tb/tb_hog_bus_drain.sv
// Randomized bench for hog_bus_drain: a bus responder plus a transaction-level
// queue model of the words the drain must deliver, in order, on the stream port.
module tb_hog_bus_drain;

  logic         clk = 1'b0;
  logic         rst_n, irq, ack, m_ready;
  logic [127:0] read_data;
  logic         bus_enable, r_wbar, m_valid, timeout_err;
  logic [4:0]   addr;
  logic [15:0]  byte_enable;
  logic [124:0] m_data;
  logic [2:0]   m_meta;
  logic [15:0]  word_count;

  hog_bus_drain dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .ack(ack), .read_data(read_data),
    .bus_enable(bus_enable), .r_wbar(r_wbar), .addr(addr), .byte_enable(byte_enable),
    .m_data(m_data), .m_meta(m_meta), .m_valid(m_valid), .m_ready(m_ready),
    .timeout_err(timeout_err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] w;
    int           vis;
  } ent_t;

  ent_t         q[$];
  int           n_vec = 0, n_err = 0;
  int           exp_wc, pend_at, dly, req_cnt, pops, cur_len, last_len;
  logic         exp_terr, prev_be, prev_ack, prev_irq;
  logic [127:0] last_obs, fixed_word;
  int           cfg_dmin, cfg_dmax, cfg_ready_pct, cfg_zero_pct;
  logic         cfg_fixed, cfg_irq_rand, cfg_noack;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [127:0] gen_word();
    logic [127:0] w;
    w = {$urandom, $urandom, $urandom, $urandom};
    if ($urandom_range(99) < cfg_zero_pct) w[127:125] = 3'b000;
    else w[127:125] = 3'($urandom_range(7, 1));
    return w;
  endfunction

  task automatic model_reset();
    q.delete();
    exp_wc = 0; pend_at = -1; dly = 0; cur_len = 0;
    exp_terr = 1'b0; prev_be = 1'b0; prev_ack = 1'b0; prev_irq = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; irq = 1'b0; ack = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One cycle at the falling edge: check outputs against the model, then drive.
  task automatic step();
    logic vis, ack_now;
    logic [127:0] w;
    if (pend_at >= 0 && cyc >= pend_at) begin
      exp_wc++;
      pend_at = -1;
    end
    if (!bus_enable && prev_be) begin
      last_len = cur_len;
      cur_len = 0;
`ifdef HOG_DRAIN_TIMEOUT_EN
      if (!prev_ack) exp_terr = 1'b1;
`endif
    end
    if (bus_enable) cur_len++;
    vis = (q.size() > 0) && (q[0].vis <= cyc);
    chk("m_valid", m_valid, vis);
    chk("word_count", word_count, exp_wc);
    chk("timeout_err", timeout_err, exp_terr);
    if (vis) begin
      chk("m_data", m_data, q[0].w[124:0]);
      chk("m_meta", m_meta, q[0].w[127:125]);
    end
    if (bus_enable) chk("bus_fields", {r_wbar, addr, byte_enable}, {1'b1, 5'd0, 16'hFFFF});
    else            chk("bus_idle", {r_wbar, addr, byte_enable}, 22'd0);
    if (prev_ack) chk("be_drop", bus_enable, 1'b0);
    else if (prev_be && !cfg_noack) chk("be_hold", bus_enable, 1'b1);
    if (bus_enable && !prev_be) begin
      req_cnt++;
      chk("issue_irq", prev_irq, 1'b1);
      chk("issue_room", q.size() < 4, 1'b1);
      dly = $urandom_range(cfg_dmax, cfg_dmin);
    end
    ack_now = 1'b0;
    read_data = {$urandom, $urandom, $urandom, $urandom};
    if (bus_enable && !cfg_noack) begin
      if (dly == 0) begin
        ack_now = 1'b1;
        w = cfg_fixed ? fixed_word : gen_word();
        read_data = w;
        if (w[127:125] != 3'b000) begin
          q.push_back('{w, cyc + 2});
          pend_at = cyc + 2;
        end
      end else begin
        dly--;
      end
    end
    ack = ack_now;
    m_ready = ($urandom_range(99) < cfg_ready_pct);
    if (vis && m_ready) begin
      last_obs = {m_meta, m_data};
      pops++;
      void'(q.pop_front());
    end
    if (cfg_irq_rand) irq = ($urandom_range(99) < 70);
    prev_be = bus_enable; prev_ack = ack_now; prev_irq = irq;
    @(negedge clk);
  endtask

  initial begin
    int r0, p0, n, max_occ;
    rst_n = 1'b0; irq = 1'b0; ack = 1'b0; m_ready = 1'b0; read_data = '0;
    cfg_dmin = 0; cfg_dmax = 0; cfg_ready_pct = 100; cfg_zero_pct = 0;
    cfg_fixed = 1'b0; cfg_irq_rand = 1'b0; cfg_noack = 1'b0;
    req_cnt = 0; pops = 0; last_len = 0; last_obs = '0; fixed_word = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    chk("rst_be", bus_enable, 1'b0);
    chk("rst_bus", {r_wbar, addr, byte_enable}, 22'd0);
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_data", {m_meta, m_data}, 128'd0);
    chk("rst_wc", word_count, 16'd0);
    chk("rst_terr", timeout_err, 1'b0);

    // Single read, ack two cycles after request.
    cfg_dmin = 2; cfg_dmax = 2; cfg_fixed = 1'b1;
    fixed_word = {3'b101, 125'h123};
    irq = 1'b1; step(); irq = 1'b0;
    repeat (8) step();
    chk("t24_len", last_len, 3);
    chk("t24_wc", word_count, 16'd1);
    chk("t24_word", last_obs, {3'b101, 125'h123});

    // Empty-marker read is discarded; FSM returns to idle.
    fixed_word = {3'b000, 125'h55};
    irq = 1'b1; step(); irq = 1'b0;
    repeat (6) step();
    chk("t26_wc", word_count, 16'd1);
    chk("t26_valid", m_valid, 1'b0);
    irq = 1'b1; step(); irq = 1'b0;
    chk("t26_idle", bus_enable, 1'b1);
    repeat (6) step();
    cfg_fixed = 1'b0;

    // Backpressure fills the FIFO; a single pop allows exactly one more read.
    cfg_dmin = 1; cfg_dmax = 1; cfg_ready_pct = 0; irq = 1'b1;
    r0 = req_cnt;
    repeat (40) step();
    chk("t25_reads", req_cnt - r0, 4);
    chk("t25_stall", bus_enable, 1'b0);
    cfg_ready_pct = 100; step(); cfg_ready_pct = 0;
    repeat (20) step();
    chk("t25_more", req_cnt - r0, 5);
    chk("t25_stall2", bus_enable, 1'b0);
    irq = 1'b0; cfg_ready_pct = 100;
    repeat (20) step();
    chk("t25_drain", m_valid, 1'b0);

    // Streaming with immediate acks and a always-ready sink.
    cfg_dmin = 0; cfg_dmax = 0; irq = 1'b1;
    p0 = pops; n = 0; max_occ = 0;
    while (pops - p0 < 100 && n < 1000) begin
      step();
      if (q.size() > max_occ) max_occ = q.size();
      n++;
    end
    chk("t29_count", (pops - p0) >= 100, 1'b1);
    chk("t29_occ", max_occ <= 1, 1'b1);
    irq = 1'b0;
    repeat (10) step();

    // Random irq, ack latency, backpressure and empty markers.
    cfg_irq_rand = 1'b1; cfg_dmin = 0; cfg_dmax = 4; cfg_ready_pct = 60; cfg_zero_pct = 20;
    repeat (600) step();
    cfg_irq_rand = 1'b0; irq = 1'b0; cfg_ready_pct = 100;
    repeat (30) step();
    chk("rand_drain", m_valid, 1'b0);

    // Reset while a read is in flight with two words queued.
    cfg_dmin = 0; cfg_dmax = 0; cfg_zero_pct = 0; cfg_ready_pct = 0; irq = 1'b1;
    n = 0;
    while (!(bus_enable === 1'b1 && q.size() == 2) && n < 60) begin
      step();
      n++;
    end
    chk("t28_setup", q.size(), 2);
    do_reset();
    chk("t28_be", bus_enable, 1'b0);
    chk("t28_valid", m_valid, 1'b0);
    chk("t28_wc", word_count, 16'd0);
    chk("t28_terr", timeout_err, 1'b0);
    cfg_ready_pct = 100;
    repeat (10) step();
    chk("t28_nopush", word_count, 16'd0);

`ifdef HOG_DRAIN_TIMEOUT_EN
    // Ack never returns: the read is abandoned and the error sticks until reset.
    cfg_noack = 1'b1; irq = 1'b1; step(); irq = 1'b0;
    repeat (270) step();
    chk("tmo_len", last_len, 255);
    chk("tmo_err", timeout_err, 1'b1);
    chk("tmo_be", bus_enable, 1'b0);
    cfg_noack = 1'b0;
    do_reset();
    chk("tmo_clear", timeout_err, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
